// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - frame constants, pixel word layout and loader states shared by display and loader
`timescale 1ns/1ps
package vga_pkg;

  localparam int         WIDTH     = 524;
  localparam int         HEIGHT    = 416;
  localparam int         TOTALSIZE = WIDTH * HEIGHT;
  localparam int         ADDR_W    = 18;
  localparam logic [7:0] SOF       = 8'hA5;

  // Pixel word: the display samples the top nibble of each colour byte.
  localparam int R_MSB = 31;
  localparam int R_LSB = 24;
  localparam int G_MSB = 23;
  localparam int G_LSB = 16;
  localparam int B_MSB = 15;
  localparam int B_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_R,
    ST_GET_G,
    ST_GET_B,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

  function automatic logic [31:0] pack_pixel(input logic [7:0] r,
                                             input logic [7:0] g,
                                             input logic [7:0] b);
    logic [31:0] w;
    w              = '0;
    w[R_MSB:R_LSB] = r;
    w[G_MSB:G_LSB] = g;
    w[B_MSB:B_LSB] = b;
    return w;
  endfunction

endpackage

// File: rtl/img_loader.sv
// rtl/img_loader.sv - packs a framed RGB byte stream into 32-bit words and writes them to the image buffer
`timescale 1ns/1ps
module img_loader
  import vga_pkg::*;
#(
  parameter int         WIDTH     = vga_pkg::WIDTH,
  parameter int         HEIGHT    = vga_pkg::HEIGHT,
  parameter int         TOTALSIZE = WIDTH * HEIGHT,
  parameter int         ADDR_W    = vga_pkg::ADDR_W,
  parameter logic [7:0] SOF       = vga_pkg::SOF,
  parameter int         TIMEOUT   = 1_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int                CNT_W    = ($clog2(TIMEOUT) > 20) ? $clog2(TIMEOUT) : 20;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTALSIZE - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              wr;

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && in_data == SOF) begin
          state_d = ST_GET_R;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_GET_R, ST_GET_G, ST_GET_B: begin
        if (accept) begin
          cnt_d = '0;
          if (state_q == ST_GET_R) begin
            r_d     = in_data;
            state_d = ST_GET_G;
          end else if (state_q == ST_GET_G) begin
            g_d     = in_data;
            state_d = ST_GET_B;
          end else begin
            b_d     = in_data;
            state_d = ST_WRITE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Stalled source: abandon the frame, keep what was already written.
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          r_d     = '0;
          g_d     = '0;
          b_d     = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          cnt_d   = '0;
          state_d = ST_GET_R;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d inside {ST_IDLE, ST_GET_R, ST_GET_G, ST_GET_B});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign wr         = (state_q == ST_WRITE);
  assign in_ready   = ready_q;
  assign bram_en    = wr;
  assign bram_we    = {4{wr}};
  assign bram_addr  = wr ? idx_q : '0;
  assign bram_din   = wr ? pack_pixel(r_q, g_q, b_q) : '0;
  assign busy       = (state_q inside {ST_GET_R, ST_GET_G, ST_GET_B, ST_WRITE});
  assign frame_done = (state_q == ST_DONE);
  assign frame_err  = err_q;

endmodule
